hilo_div_unit: RTL

- Parametrised multi-cycle restoring divider for DIV/DIVU, owned by the EXE stage.
- Result feeds the HI/LO write path: remainder goes to HI, quotient to LO.
- Asserts a stall request toward the pipeline while a division is in flight.
- Generalises the single-cycle multiply path:
  - configurable operand width;
  - signed/unsigned mode per operation;
  - cancel on flush;
  - defined divide-by-zero result.

---
 rtl/hilo_div_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/hilo_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: remainder feeds HI, quotient feeds LO.
// Define DIV_ZERO_FAST_EN to finish a divide-by-zero in one cycle instead of WIDTH+1.
module hilo_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_req,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dq_q, dq_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] orig_q, orig_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             zero_q, zero_d;
  logic             dbz_q, dbz_d;

  // Operand magnitudes; the most negative value maps onto itself read as unsigned.
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  assign dvd_mag = (sign && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
  assign dsr_mag = (sign && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;

  // One restoring step: dq_q shifts dividend bits out the top and quotient bits in at the bottom.
  logic [WIDTH:0]   diff;
  logic             qbit;
  logic [WIDTH-1:0] acc_nxt, dq_nxt;
  assign diff    = {acc_q, dq_q[WIDTH-1]} - {1'b0, dsr_q};
  assign qbit    = ~diff[WIDTH];
  assign acc_nxt = qbit ? diff[WIDTH-1:0] : {acc_q[WIDTH-2:0], dq_q[WIDTH-1]};
  assign dq_nxt  = {dq_q[WIDTH-2:0], qbit};

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      dq_q      <= '0;
      dsr_q     <= '0;
      orig_q    <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      zero_q    <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dq_q      <= dq_d;
      dsr_q     <= dsr_d;
      orig_q    <= orig_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      zero_q    <= zero_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dq_d      = dq_q;
    dsr_d     = dsr_q;
    orig_d    = orig_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    zero_d    = zero_q;
    dbz_d     = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          acc_d     = '0;
          dq_d      = dvd_mag;
          dsr_d     = dsr_mag;
          orig_d    = dividend;
          neg_quo_d = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = sign & dividend[WIDTH-1];
          zero_d    = (divisor == '0);
          cnt_d     = '0;
          state_d   = S_CALC;
`ifdef DIV_ZERO_FAST_EN
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_d = acc_nxt;
          dq_d  = dq_nxt;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_DONE;
            if (zero_q) begin
              quo_d = '1;
              rem_d = orig_q;
              dbz_d = 1'b1;
            end else begin
              quo_d = neg_quo_q ? (~dq_nxt + WIDTH'(1)) : dq_nxt;
              rem_d = neg_rem_q ? (~acc_nxt + WIDTH'(1)) : acc_nxt;
              dbz_d = 1'b0;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy        = (state_q == S_CALC) || (state_q == S_DONE);
  assign stall_req   = ((state_q == S_IDLE) && start && !cancel) || (state_q == S_CALC);
  assign done        = (state_q == S_DONE) && !cancel;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
